t07_simon_sequencer: RTL and testbench

Game-control stage for the Simon memory module. It sits directly upstream of the Simon light controller and produces `simon_state`, `simon_sequence_bus` and `simon_cleared` for it.
- Generates a 5-colour random sequence from a free-running LFSR.
- Times each display phase so it matches the light controller's playback.
- Checks the player's button presses against the sequence.
- Reports a strike on a wrong press and reports cleared after stage 5.

---
 rtl/t07_simon_sequencer_if.sv | 21 ++
 rtl/t07_simon_sequencer.sv | 174 +++++++++++++++++
 tb/tb_t07_simon_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t07_simon_sequencer_if.sv
// Signal bundle between the game controller and the Simon sequencer.
// The sequencer is the slave; whoever drives enable/strobe/presses is the master.
interface t07_simon_sequencer_if;
   logic       enable;
   logic       s_strobe;
   logic [5:0] button_pulse;
   logic [3:0] simon_state;
   logic [9:0] simon_sequence_bus;
   logic       simon_cleared;
   logic       simon_strike;

   modport master (
      output enable, s_strobe, button_pulse,
      input  simon_state, simon_sequence_bus, simon_cleared, simon_strike
   );

   modport slave (
      input  enable, s_strobe, button_pulse,
      output simon_state, simon_sequence_bus, simon_cleared, simon_strike
   );
endinterface

// File: rtl/t07_simon_sequencer.sv
// Simon game-control stage: draws a 5-colour sequence from a free-running LFSR,
// paces display phases, checks player presses, and reports strike / cleared.
module t07_simon_sequencer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned TIMEOUT_S = 8
) (
   input logic                  clk,
   input logic                  nrst,
   t07_simon_sequencer_if.slave bus_if
);

   typedef enum logic [3:0] {
      ST_D1   = 4'd0,
      ST_I1   = 4'd1,
      ST_D2   = 4'd2,
      ST_I2   = 4'd3,
      ST_D3   = 4'd4,
      ST_I3   = 4'd5,
      ST_D4   = 4'd6,
      ST_I4   = 4'd7,
      ST_D5   = 4'd8,
      ST_I5   = 4'd9,
      ST_DONE = 4'd10
   } state_t;

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT_S);

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic        enable_q;
   logic [3:0]  dwell_cnt_q;
   logic [3:0]  idle_cnt_q;
   logic [2:0]  press_idx_q;
   logic [9:0]  seq_q;
   logic        cleared_q;
   logic        strike_q;

   logic [2:0]  stage_k;
   logic [3:0]  dwell_target;
   logic [3:0]  dwell_inc;
   logic [3:0]  idle_inc;
   logic        press_valid;
   logic [1:0]  press_colour;
   logic [1:0]  expected_colour;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // D/I state pairs share a stage index: code = 2k (display) or 2k+1 (input)
   assign stage_k      = state_q[3:1];
   assign dwell_target = {1'b0, stage_k} + 4'd5;
   assign dwell_inc    = dwell_cnt_q + 4'd1;
   assign idle_inc     = idle_cnt_q + 4'd1;

   always_comb begin
      press_valid  = 1'b1;
      press_colour = 2'd0;
      case (bus_if.button_pulse)
         6'b000010: press_colour = 2'd0;
         6'b000100: press_colour = 2'd1;
         6'b001000: press_colour = 2'd2;
         6'b010000: press_colour = 2'd3;
         default:   press_valid  = 1'b0;
      endcase
   end

   always_comb begin
      expected_colour = 2'd0;
      case (press_idx_q)
         3'd0:    expected_colour = seq_q[1:0];
         3'd1:    expected_colour = seq_q[3:2];
         3'd2:    expected_colour = seq_q[5:4];
         3'd3:    expected_colour = seq_q[7:6];
         3'd4:    expected_colour = seq_q[9:8];
         default: expected_colour = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_D1;
         enable_q    <= 1'b0;
         dwell_cnt_q <= 4'd0;
         idle_cnt_q  <= 4'd0;
         press_idx_q <= 3'd0;
         seq_q       <= 10'd0;
         cleared_q   <= 1'b0;
         strike_q    <= 1'b0;
      end else begin
         enable_q <= bus_if.enable;
         strike_q <= 1'b0;
         if (!bus_if.enable) begin
            state_q     <= ST_D1;
            cleared_q   <= 1'b0;
            dwell_cnt_q <= 4'd0;
            idle_cnt_q  <= 4'd0;
            press_idx_q <= 3'd0;
         end else if (!enable_q) begin
            seq_q       <= lfsr_q[9:0];
            state_q     <= ST_D1;
            cleared_q   <= 1'b0;
            dwell_cnt_q <= 4'd0;
            idle_cnt_q  <= 4'd0;
            press_idx_q <= 3'd0;
         end else begin
            case (state_q)
               ST_D1, ST_D2, ST_D3, ST_D4, ST_D5: begin
                  if (bus_if.s_strobe) begin
                     if (dwell_inc == dwell_target) begin
                        state_q     <= state_t'(state_q + 4'd1);
                        dwell_cnt_q <= 4'd0;
                     end else begin
                        dwell_cnt_q <= dwell_inc;
                     end
                  end
               end
               ST_I1, ST_I2, ST_I3, ST_I4, ST_I5: begin
                  // A press beats a coincident strobe, so it is checked first
                  if (press_valid) begin
                     idle_cnt_q <= 4'd0;
                     if (press_colour == expected_colour) begin
                        if (press_idx_q == stage_k) begin
                           state_q     <= state_t'(state_q + 4'd1);
                           press_idx_q <= 3'd0;
                           if (state_q == ST_I5) begin
                              cleared_q <= 1'b1;
                           end
                        end else begin
                           press_idx_q <= press_idx_q + 3'd1;
                        end
                     end else begin
                        strike_q    <= 1'b1;
                        state_q     <= state_t'(state_q - 4'd1);
                        press_idx_q <= 3'd0;
                     end
                  end else if (bus_if.s_strobe) begin
                     if (idle_inc == TIMEOUT_CNT) begin
                        state_q     <= state_t'(state_q - 4'd1);
                        idle_cnt_q  <= 4'd0;
                        press_idx_q <= 3'd0;
                     end else begin
                        idle_cnt_q <= idle_inc;
                     end
                  end
               end
               ST_DONE: begin
                  cleared_q <= 1'b1;
               end
               default: begin
                  state_q     <= ST_D1;
                  cleared_q   <= 1'b0;
                  dwell_cnt_q <= 4'd0;
                  idle_cnt_q  <= 4'd0;
                  press_idx_q <= 3'd0;
               end
            endcase
         end
      end
   end

   assign bus_if.simon_state        = state_q;
   assign bus_if.simon_sequence_bus = seq_q;
   assign bus_if.simon_cleared      = cleared_q;
   assign bus_if.simon_strike       = strike_q;

endmodule

// File: tb/tb_t07_simon_sequencer.sv
// Scoreboard bench for the Simon sequencer: stimulus pushes per-cycle expectations
// from a stage/phase reference model; a monitor pops and compares after each clock edge.
module tb_t07_simon_sequencer;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic [3:0] st;
      logic [9:0] seq;
      logic       clr;
      logic       stk;
   } exp_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   t07_simon_sequencer_if sif();

   t07_simon_sequencer #(
      .LFSR_SEED(16'hACE1),
      .TIMEOUT_S(TIMEOUT)
   ) dut (
      .clk   (clk),
      .nrst  (nrst),
      .bus_if(sif)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;
   exp_t        exp_q[$];

   // Reference model: stage 1..5, phase 0=display 1=input 2=done
   logic [15:0] m_lfsr;
   logic        m_en_prev;
   int          m_seq[5];
   int          m_stage, m_phase, m_dwell, m_idx, m_idle;
   logic        m_clr, m_stk;

   function automatic logic [5:0] col_btn(input int c);
      logic [5:0] b;
      b = 6'b000010;
      return b << c;
   endfunction

   function automatic void model_clear_game();
      m_stage = 1; m_phase = 0; m_dwell = 0; m_idx = 0; m_idle = 0; m_clr = 1'b0;
   endfunction

   function automatic void model_reset();
      m_lfsr = 16'hACE1; m_en_prev = 1'b0; m_stk = 1'b0;
      for (int k = 0; k < 5; k++) m_seq[k] = 0;
      model_clear_game();
   endfunction

   function automatic void model_step(input logic en, input logic st, input logic [5:0] btn, input logic rn);
      logic [15:0] old;
      int col;
      if (!rn) begin
         model_reset();
         return;
      end
      col = -1;
      for (int c = 0; c < 4; c++) if (btn == col_btn(c)) col = c;
      old    = m_lfsr;
      m_lfsr = {old[14:0], old[15] ^ old[13] ^ old[12] ^ old[10]};
      m_stk  = 1'b0;
      if (!en) begin
         model_clear_game();
      end else if (!m_en_prev) begin
         for (int k = 0; k < 5; k++) m_seq[k] = int'(old[2*k +: 2]);
         model_clear_game();
      end else if (m_phase == 0) begin
         if (st) begin
            m_dwell++;
            if (m_dwell == m_stage + 4) begin m_phase = 1; m_dwell = 0; end
         end
      end else if (m_phase == 1) begin
         if (col >= 0) begin
            m_idle = 0;
            if (col == m_seq[m_idx]) begin
               if (m_idx == m_stage - 1) begin
                  m_idx = 0;
                  if (m_stage == 5) begin m_phase = 2; m_clr = 1'b1; end
                  else begin m_stage++; m_phase = 0; end
               end else begin
                  m_idx++;
               end
            end else begin
               m_stk = 1'b1; m_phase = 0; m_idx = 0;
            end
         end else if (st) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_phase = 0; m_idle = 0; m_idx = 0; end
         end
      end
      m_en_prev = en;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.st  = (m_phase == 2) ? 4'd10 : 4'((m_stage - 1) * 2 + m_phase);
      for (int k = 0; k < 5; k++) e.seq[2*k +: 2] = 2'(m_seq[k]);
      e.clr = m_clr;
      e.stk = m_stk;
      return e;
   endfunction

   task automatic cyc(input logic en, input logic st, input logic [5:0] btn, input logic rn);
      @(negedge clk);
      nrst             = rn;
      sif.enable       = en;
      sif.s_strobe     = st;
      sif.button_pulse = btn;
      model_step(en, st, btn, rn);
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 1'b0, 6'd0, 1'b1);
   endtask

   task automatic strobe();
      cyc(1'b1, 1'b1, 6'd0, 1'b1);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
   endtask

   task automatic press(input logic [5:0] b);
      cyc(1'b1, 1'b0, b, 1'b1);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic reach_input();
      int n;
      n = 0;
      while (m_phase == 0 && n < 20) begin
         strobe();
         n++;
      end
      if (m_phase != 1) begin
         total++; bad++;
         $display("FAIL reach_input: phase %0d after %0d strobes, required 1", m_phase, n);
      end
   endtask

   task automatic play_inputs();
      int s;
      int cols[5];
      s = m_stage;
      for (int k = 0; k < 5; k++) cols[k] = m_seq[k];
      for (int i = 0; i < s; i++) press(col_btn(cols[i]));
   endtask

   // Monitor: one expectation per clock edge, sampled 1 time unit after it
   initial begin
      exp_t e;
      exp_t got;
      logic [3:0] last_st;
      last_st = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {sif.simon_state, sif.simon_sequence_bus, sif.simon_cleared, sif.simon_strike};
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL cycle_out: state=%0d bus=%h clr=%b stk=%b, required state=%0d bus=%h clr=%b stk=%b",
                        got.st, got.seq, got.clr, got.stk, e.st, e.seq, e.clr, e.stk);
            end else if (got.st != last_st || got.stk) begin
               $display("txn t=%0t state=%0d bus=%h cleared=%b strike=%b", $time, got.st, got.seq, got.clr, got.stk);
            end
            last_st = got.st;
         end
      end
   end

   initial begin
      int wait_n;
      logic en_r, st_r, rn_r;
      logic [5:0] b_r;
      int r;

      sif.enable = 1'b0; sif.s_strobe = 1'b0; sif.button_pulse = 6'd0;
      nrst = 1'b0;
      model_reset();
      #2;
      chk("rst_state", 16'(sif.simon_state), 16'd0);
      chk("rst_bus", 16'(sif.simon_sequence_bus), 16'd0);
      chk("rst_cleared", 16'(sif.simon_cleared), 16'd0);
      chk("rst_strike", 16'(sif.simon_strike), 16'd0);

      // Start straight out of reset: bus captures the seed's low 10 bits
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      idle(2);
      repeat (4) strobe();
      press(6'b000100);
      strobe();
      press(6'b000100);
      repeat (6) strobe();
      press(6'b000100);
      press(6'b000010);
      repeat (7) strobe();
      idle(1);

      // Async reset mid-I3 must clear outputs without waiting for a clock
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      #1;
      chk("arst_state", 16'(sif.simon_state), 16'd0);
      chk("arst_bus", 16'(sif.simon_sequence_bus), 16'd0);
      chk("arst_cleared", 16'(sif.simon_cleared), 16'd0);
      chk("arst_strike", 16'(sif.simon_strike), 16'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);

      // I2: ignored patterns, then RIGHT, DOWN (wrong) -> strike and D2
      repeat (5) strobe();
      press(6'b000100);
      repeat (6) strobe();
      press(6'b000001);
      press(6'b000110);
      press(6'b100000);
      press(6'b000100);
      press(6'b001000);

      // Press coincident with the 7th idle strobe resets the timeout
      repeat (6) strobe();
      repeat (TIMEOUT - 2) strobe();
      cyc(1'b1, 1'b1, 6'b000100, 1'b1);
      idle(1);
      repeat (TIMEOUT) strobe();

      // Full playthrough to DONE, then ignored inputs in DONE
      for (int n = 0; n < 6 && m_phase != 2; n++) begin
         reach_input();
         play_inputs();
      end
      if (m_phase != 2) begin
         total++; bad++;
         $display("FAIL playthrough: model phase %0d, required 2", m_phase);
      end
      strobe();
      press(6'b000010);
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      cyc(1'b0, 1'b1, 6'b000100, 1'b1);

      // Restart captures a new sequence; I1 timeout without presses
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      reach_input();
      repeat (TIMEOUT) strobe();

      // Randomised play
      for (int i = 0; i < 3000; i++) begin
         en_r = ($urandom_range(0, 199) != 0);
         rn_r = ($urandom_range(0, 599) != 0);
         st_r = ($urandom_range(0, 2) == 0);
         r    = $urandom_range(0, 9);
         if (r < 4 && m_phase == 1) b_r = col_btn(m_seq[m_idx]);
         else if (r < 6) b_r = col_btn($urandom_range(0, 3));
         else if (r == 6) b_r = 6'($urandom);
         else b_r = 6'd0;
         cyc(en_r, st_r, b_r, rn_r);
      end

      wait_n = 0;
      while (exp_q.size() > 0 && wait_n < 10) begin
         @(posedge clk);
         #2;
         wait_n++;
      end
      if (exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
